// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter.
// Holds the state encoding, size limits and a clog2 helper.
package arb_pkg;

  localparam int MAX_REQ = 16;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // Never returns less than 1 so index fields stay legal.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: the first set request at or after
// ptr, wrapping, wins.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int j;
    win = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any    = 1'b1;
        win[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_n.sv
// N-way round-robin arbiter with registered one-hot grant
// and bounded grant hold under lock.
module rr_arbiter_n
  import arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int LOCK_EN  = 1,
  parameter int MAX_HOLD = 8,
  localparam int IW = clog2(NUM_REQ),
  localparam int CW = clog2(MAX_HOLD + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] lock,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [IW-1:0]      gnt_id,
  output logic               hold_expired
);

  localparam logic [CW-1:0] MAX_C = CW'(MAX_HOLD);
  localparam logic [IW-1:0] LAST  = IW'(NUM_REQ - 1);

  arb_state_t         state;
  logic [IW-1:0]      ptr;
  logic [CW-1:0]      cnt;
  logic [NUM_REQ-1:0] pick_win;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;
  logic [IW-1:0]      next_ptr;
  logic               held;
  logic               keep;
  logic               expire;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req (req),
    .ptr (ptr),
    .win (pick_win),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Lock only counts while the grantee is still requesting.
  assign held = (LOCK_EN != 0) && (state == ARB_GRANT)
             && lock[gnt_id] && req[gnt_id];
  assign keep     = held && (cnt < MAX_C);
  assign expire   = held && (cnt == MAX_C);
  assign next_ptr = (pick_idx == LAST) ? '0
                  : pick_idx + IW'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= ARB_IDLE;
      ptr          <= '0;
      cnt          <= '0;
      gnt          <= '0;
      gnt_valid    <= 1'b0;
      gnt_id       <= '0;
      hold_expired <= 1'b0;
    end else if (keep) begin
      cnt          <= cnt + CW'(1);
      hold_expired <= 1'b0;
    end else begin
      hold_expired <= expire;
      if (pick_any) begin
        state     <= ARB_GRANT;
        gnt       <= pick_win;
        gnt_valid <= 1'b1;
        gnt_id    <= pick_idx;
        ptr       <= next_ptr;
        cnt       <= CW'(1);
      end else begin
        state     <= ARB_IDLE;
        gnt       <= '0;
        gnt_valid <= 1'b0;
        gnt_id    <= '0;
        cnt       <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Scoreboard bench for rr_arbiter_n: a locking instance and
// a LOCK_EN=0 instance, both NUM_REQ=4.
module tb_rr_arbiter_n;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] req   = '0;
  logic [3:0] lock  = '0;
  logic [3:0] req0  = '0;
  logic [3:0] lock0 = '0;
  logic [3:0] gnt, gnt0;
  logic       gnt_valid, gnt_valid0;
  logic [1:0] gnt_id, gnt_id0;
  logic       hold_expired, hold_expired0;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic       which;
    logic [3:0] g;
    logic       he;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];

  rr_arbiter_n #(.NUM_REQ(4), .LOCK_EN(1), .MAX_HOLD(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .req          (req),
    .lock         (lock),
    .gnt          (gnt),
    .gnt_valid    (gnt_valid),
    .gnt_id       (gnt_id),
    .hold_expired (hold_expired)
  );

  rr_arbiter_n #(.NUM_REQ(4), .LOCK_EN(0), .MAX_HOLD(8)) dut0 (
    .clock        (clock),
    .reset        (reset),
    .req          (req0),
    .lock         (lock0),
    .gnt          (gnt0),
    .gnt_valid    (gnt_valid0),
    .gnt_id       (gnt_id0),
    .hold_expired (hold_expired0)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (!reset) begin
      assert ($onehot0(gnt)) else $error("gnt multi-hot %b", gnt);
      assert ($onehot0(gnt0)) else $error("gnt0 multi-hot %b", gnt0);
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] id_of(input logic [3:0] g);
    logic [1:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)
      if (g[i]) r = 2'(i);
    return r;
  endfunction

  task automatic step(input logic which, input logic [3:0] r,
                      input logic [3:0] l, input logic [3:0] eg,
                      input logic eh, input string tag);
    exp_t  e;
    string t;
    @(negedge clock);
    if (which) begin
      req0 = r; lock0 = l;
    end else begin
      req = r; lock = l;
    end
    exp_q.push_back('{which: which, g: eg, he: eh});
    tag_q.push_back(tag);
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    if (e.which) begin
      check({t, ".gnt"}, 32'(gnt0), 32'(e.g));
      check({t, ".vld"}, 32'(gnt_valid0), 32'(|e.g));
      check({t, ".id"}, 32'(gnt_id0), 32'(id_of(e.g)));
      check({t, ".he"}, 32'(hold_expired0), 32'(e.he));
    end else begin
      check({t, ".gnt"}, 32'(gnt), 32'(e.g));
      check({t, ".vld"}, 32'(gnt_valid), 32'(|e.g));
      check({t, ".id"}, 32'(gnt_id), 32'(id_of(e.g)));
      check({t, ".he"}, 32'(hold_expired), 32'(e.he));
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, ".gnt"}, 32'(gnt), 32'h0);
    check({tag, ".vld"}, 32'(gnt_valid), 32'h0);
    check({tag, ".id"}, 32'(gnt_id), 32'h0);
    check({tag, ".he"}, 32'(hold_expired), 32'h0);
    check({tag, ".gnt0"}, 32'(gnt0), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    #2 reset = 1'b1;
    #1 check_reset_outs("rst_init");
    req = 4'b1111;
    @(posedge clock);
    check_reset_outs("rst_hold");
    #2 reset = 1'b0;

    for (int i = 0; i < 8; i++)
      step(1'b0, 4'b1111, 4'b0000, 4'(4'b0001 << (i % 4)), 1'b0, "rot");

    @(negedge clock);
    reset = 1'b1;
    #1 check_reset_outs("rst_mid");
    @(posedge clock);
    #2 reset = 1'b0;
    step(1'b0, 4'b1111, 4'b0000, 4'b0001, 1'b0, "rst_first");

    step(1'b0, 4'b0100, 4'b0000, 4'b0100, 1'b0, "ptr3");
    step(1'b0, 4'b0101, 4'b0000, 4'b0001, 1'b0, "wrap");
    step(1'b0, 4'b0101, 4'b0000, 4'b0100, 1'b0, "skip");
    step(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, "idle");

    for (int i = 0; i < 8; i++)
      step(1'b0, 4'b0011, 4'b0001, 4'b0001, 1'b0, "lock_hold");
    step(1'b0, 4'b0011, 4'b0001, 4'b0010, 1'b1, "expire");
    step(1'b0, 4'b0011, 4'b0001, 4'b0001, 1'b0, "after_exp");
    step(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, "idle2");

    for (int i = 0; i < 3; i++)
      step(1'b0, 4'b0100, 4'b0100, 4'b0100, 1'b0, "lock2");
    step(1'b0, 4'b1001, 4'b0100, 4'b1000, 1'b0, "drop2");
    step(1'b0, 4'b1001, 4'b0001, 4'b0001, 1'b0, "lock_other");
    step(1'b0, 4'b0100, 4'b0100, 4'b0100, 1'b0, "lock2b");
    step(1'b0, 4'b0000, 4'b0100, 4'b0000, 1'b0, "drop_idle");

    for (int i = 0; i < 12; i++)
      step(1'b1, 4'b0010, 4'b0010, 4'b0010, 1'b0, "nolock");
    step(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, "nolock_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_n.md
Name: rr_arbiter_n

Overview:
- Parametrised N-requester round-robin arbiter with registered, one-hot grants and optional grant hold (lock) for multi-cycle transactions.
- Next-generation arbiter for shared-resource access, e.g. a shared 8-bit address/data bus among several initiators.
- Fairness by rotating priority pointer; each grant drives a tri-state bus owner select downstream (bus drive not inside this block).

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- LOCK_EN, 1, when 1 a granted requester holding lock_i keeps the grant beyond one cycle.
- MAX_HOLD, 8, max consecutive cycles one grant may be held under lock before forced rotation (1..255).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  request vector, bit i = requester i.
- lock  input  NUM_REQ  per-requester hold request; only meaningful for current grantee.
- gnt  output  NUM_REQ  registered one-hot (or zero) grant.
- gnt_valid  output  1  high when gnt is nonzero.
- gnt_id  output  clog2(NUM_REQ)  binary index of current grantee; 0 when gnt_valid low.
- hold_expired  output  1  one-cycle pulse when MAX_HOLD forces rotation.

Behaviour:
- Reset (async assert, sync deassert at system level): gnt=0, gnt_valid=0, gnt_id=0, hold_expired=0, priority pointer=0 (requester 0 highest), hold counter=0, state IDLE.
- States: IDLE (no grant), GRANT (one grant active).
- Arbitration each rising edge: search req starting at pointer, wrapping modulo NUM_REQ; first set bit wins. Grant appears on the edge after req sampled (latency 1 cycle).
- On grant to i: pointer <= (i+1) mod NUM_REQ; hold counter <= 1.
- IDLE -> GRANT when any req high; stays IDLE otherwise.
- GRANT, grantee i:
  - If LOCK_EN and lock[i] and req[i] and counter < MAX_HOLD: keep gnt[i], counter+1, pointer unchanged.
  - If counter == MAX_HOLD and lock still asserted: hold_expired pulses for one cycle; re-arbitrate from pointer (i itself is lowest priority and wins only if alone).
  - Otherwise re-arbitrate from pointer; if no req, -> IDLE, gnt=0.
- Grant is never given to a requester whose req was low at the sampling edge.
- Requester dropping req while granted: grant removed next edge (lock ignored without req).
- lock on non-grantee: ignored.
- LOCK_EN=0: every grant lasts exactly one cycle; back-to-back grants to the same sole requester are allowed.
- All requests high continuously, no lock: grants rotate 0,1,...,NUM_REQ-1,0... one per cycle.
- Pointer wrap: grant to NUM_REQ-1 sets pointer to 0.
- Reset mid-grant: gnt cleared immediately (asynchronously), pointer to 0.
- gnt is never multi-hot (assertion in bench).
- Hold counter width: clog2(MAX_HOLD+1), saturates, never wraps.

Decomposition:
- Shared package arb_pkg: clog2 function, ARB_IDLE/ARB_GRANT state constants, max-requester constant 16.
- One sub-module: rr_pick (combinational rotate-priority encoder: req vector + pointer -> one-hot winner + index + any flag). Top holds the FSM, pointer, hold counter and output registers.

Test Plan:
- Reset check: assert reset with req=4'b1111 mid-grant -> gnt=0, gnt_valid=0, gnt_id=0 immediately; after release, first grant is gnt=4'b0001.
- Fair rotation: NUM_REQ=4, req=4'b1111, lock=0 for 8 cycles -> gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000.
- Skip and wrap: pointer=3, req=4'b0101 -> gnt=0001 (wrap past 3), then next cycle gnt=0100.
- Lock and expiry: MAX_HOLD=8, req=4'b0011, lock=4'b0001 held -> gnt=0001 for 8 cycles, hold_expired=1 on the 9th edge with gnt=0010.
- Early release: requester 2 locked, drops req after 3 cycles -> gnt[2] clears next edge, next requester from pointer 3 granted, or IDLE if req=0.
- LOCK_EN=0, only req[1] high with lock[1]=1 -> gnt=0010 every cycle, hold_expired never pulses.
